// File: rtl/rtsnoc_pkg.sv
// rtsnoc_pkg: shared RTSNoC field positions, FSM states and bus-width helpers
package rtsnoc_pkg;
  localparam int CMD_WE = 15;
  localparam int CMD_SEL_LSB = 8;
  localparam int CMD_TAG_LSB = 0;
  localparam int STAT_TAG_LSB = 8;
  localparam int STAT_ERR = 2;
  localparam int STAT_TMO = 1;
  localparam int STAT_OK = 0;
  typedef enum logic [3:0] {
    ST_IDLE, ST_RX_ADR_H, ST_RX_ADR_L, ST_RX_DAT_H, ST_RX_DAT_L,
    ST_BUS, ST_TX_STAT, ST_TX_DAT_H, ST_TX_DAT_L
  } state_t;
  function automatic int rtsnoc_hdr(int sx, int sy);
    return 2 * (sx + sy + 3);
  endfunction
  function automatic int rtsnoc_bus_size(int dw, int sx, int sy);
    return dw + rtsnoc_hdr(sx, sy);
  endfunction
  function automatic logic [15:0] stat_flit(logic [7:0] tag, logic err, logic tmo, logic ok);
    logic [15:0] s = '0;
    s[STAT_TAG_LSB +: 8] = tag;
    s[STAT_ERR] = err;
    s[STAT_TMO] = tmo;
    s[STAT_OK] = ok;
    return s;
  endfunction
endpackage

// File: rtl/rtsnoc_wishbone_master_if.sv
// rtsnoc_wishbone_master_if: single 32-bit Wishbone bus between bridge and local slave
interface rtsnoc_wishbone_master_if;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i, err_i;
  modport master (output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o, input dat_i, ack_i, err_i);
  modport slave (input cyc_o, stb_o, we_o, adr_o, sel_o, dat_o, output dat_i, ack_i, err_i);
endinterface

// File: rtl/rtsnoc_flit_pack.sv
// rtsnoc_flit_pack: combinational pack/unpack of {orig, dst, data} NoC flits
module rtsnoc_flit_pack import rtsnoc_pkg::*; #(
  parameter int SX = 1,
  parameter int SY = 1,
  parameter int DW = 16,
  localparam int OW = SX + SY + 3,
  localparam int BW = rtsnoc_bus_size(DW, SX, SY)
) (
  input  logic [OW-1:0] tx_orig,
  input  logic [OW-1:0] tx_dst,
  input  logic [DW-1:0] tx_data,
  output logic [BW-1:0] tx_bus,
  input  logic [BW-1:0] rx_bus,
  output logic [OW-1:0] rx_orig,
  output logic [OW-1:0] rx_dst,
  output logic [DW-1:0] rx_data
);
  assign tx_bus = {tx_orig, tx_dst, tx_data};
  assign {rx_orig, rx_dst, rx_data} = rx_bus;
endmodule

// File: rtl/rtsnoc_wishbone_master.sv
// rtsnoc_wishbone_master: NoC request packets in, single Wishbone cycles out, response packets back
module rtsnoc_wishbone_master import rtsnoc_pkg::*; #(
  parameter int NOC_LOCAL_ADR = 0,
  parameter int NOC_X = 0,
  parameter int NOC_Y = 0,
  parameter int SOC_SIZE_X = 1,
  parameter int SOC_SIZE_Y = 1,
  parameter int NOC_DATA_WIDTH = 16,
  parameter int WB_TIMEOUT = 255,
  localparam int NOC_BUS_SIZE = rtsnoc_bus_size(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NOC_BUS_SIZE-1:0] noc_dout_i,
  input  logic                    noc_nd_i,
  output logic                    noc_rd_o,
  output logic [NOC_BUS_SIZE-1:0] noc_din_o,
  output logic                    noc_wr_o,
  input  logic                    noc_wait_i,
  rtsnoc_wishbone_master_if.master wb
);
  localparam int OW = SOC_SIZE_X + SOC_SIZE_Y + 3;
  localparam logic [OW-1:0] OWN = {NOC_X[SOC_SIZE_X-1:0], NOC_Y[SOC_SIZE_Y-1:0], NOC_LOCAL_ADR[2:0]};
  state_t state, state_nxt;
  logic [OW-1:0] org_r, rx_org, rx_dst_unused;
  logic [15:0] rx_data, tx_data;
  logic [NOC_BUS_SIZE-1:0] tx_bus;
  logic [7:0] tag_r, cnt;
  logic [3:0] sel_r;
  logic [31:0] adr_r, dat_r, rdat_r;
  logic we_r, err_r, tmo_r, ok_r;
  logic take, acc, send, tmo, done;
  rtsnoc_flit_pack #(.SX(SOC_SIZE_X), .SY(SOC_SIZE_Y), .DW(NOC_DATA_WIDTH)) u_pack (
    .tx_orig(OWN), .tx_dst(org_r), .tx_data(tx_data), .tx_bus(tx_bus),
    .rx_bus(noc_dout_i), .rx_orig(rx_org), .rx_dst(rx_dst_unused), .rx_data(rx_data)
  );
  // noc_rd_o doubles as the dead-cycle marker after each consumed flit
  assign take = state inside {ST_IDLE, ST_RX_ADR_H, ST_RX_ADR_L, ST_RX_DAT_H, ST_RX_DAT_L} && noc_nd_i && !noc_rd_o;
  assign acc = take && (state == ST_IDLE || rx_org == org_r);
  assign send = state inside {ST_TX_STAT, ST_TX_DAT_H, ST_TX_DAT_L} && !noc_wait_i && !noc_wr_o;
  assign tmo = cnt == 8'(WB_TIMEOUT - 1);
  assign done = state == ST_BUS && (wb.ack_i || wb.err_i || tmo);
  assign wb.cyc_o = state == ST_BUS;
  assign wb.stb_o = state == ST_BUS;
  assign wb.we_o = state == ST_BUS && we_r;
  assign wb.adr_o = adr_r;
  assign wb.sel_o = sel_r;
  assign wb.dat_o = dat_r;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    tx_data = state == ST_TX_STAT ? stat_flit(tag_r, err_r, tmo_r, ok_r) :
              state == ST_TX_DAT_H ? rdat_r[31:16] : rdat_r[15:0];
    case (state)
      ST_IDLE:     if (acc) state_nxt = ST_RX_ADR_H;
      ST_RX_ADR_H: if (acc) state_nxt = ST_RX_ADR_L;
      ST_RX_ADR_L: if (acc) state_nxt = we_r ? ST_RX_DAT_H : ST_BUS;
      ST_RX_DAT_H: if (acc) state_nxt = ST_RX_DAT_L;
      ST_RX_DAT_L: if (acc) state_nxt = ST_BUS;
      ST_BUS:      if (done) state_nxt = ST_TX_STAT;
      ST_TX_STAT:  if (send) state_nxt = we_r ? ST_IDLE : ST_TX_DAT_H;
      ST_TX_DAT_H: if (send) state_nxt = ST_TX_DAT_L;
      ST_TX_DAT_L: if (send) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      noc_rd_o <= 1'b0;
      noc_wr_o <= 1'b0;
      noc_din_o <= '0;
      cnt <= '0;
      org_r <= '0;
      tag_r <= '0;
      sel_r <= '0;
      we_r <= 1'b0;
      adr_r <= '0;
      dat_r <= '0;
      rdat_r <= '0;
      ok_r <= 1'b0;
      err_r <= 1'b0;
      tmo_r <= 1'b0;
    end else begin
      noc_rd_o <= take;
      noc_wr_o <= send;
      cnt <= state == ST_BUS ? cnt + 8'd1 : 8'd0;
      if (send) noc_din_o <= tx_bus;
      if (acc)
        case (state)
          ST_IDLE: begin
            we_r <= rx_data[CMD_WE];
            sel_r <= rx_data[CMD_SEL_LSB +: 4];
            tag_r <= rx_data[CMD_TAG_LSB +: 8];
            org_r <= rx_org;
          end
          ST_RX_ADR_H: adr_r[31:16] <= rx_data;
          ST_RX_ADR_L: adr_r[15:0] <= rx_data;
          ST_RX_DAT_H: dat_r[31:16] <= rx_data;
          ST_RX_DAT_L: dat_r[15:0] <= rx_data;
          default: ;
        endcase
      // ack wins over err, err over timeout; data is zeroed unless acked
      if (done) begin
        ok_r <= wb.ack_i;
        err_r <= !wb.ack_i && wb.err_i;
        tmo_r <= !wb.ack_i && !wb.err_i;
        rdat_r <= wb.ack_i ? wb.dat_i : 32'd0;
      end
    end
endmodule
